booth_iter_ctrl: RTL and testbench

BOOTH_ITER_CTRL -- requirements
Module: booth_iter_ctrl

---
 rtl/booth_pkg.sv | 75 +++++++
 rtl/booth_iter_ctrl_if.sv | 29 ++
 rtl/booth_lane_step.sv | 21 ++
 rtl/booth_iter_ctrl.sv | 126 ++++++++++++
 tb/tb_booth_iter_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared types, lane geometry and packing helpers for the iterative Booth multiplier controller.
package booth_pkg;

  typedef enum logic [1:0] {
    Mode1x16 = 2'b00,
    Mode2x8  = 2'b01,
    Mode4x4  = 2'b10,
    ModeRsvd = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  localparam int unsigned DataW = 16;
  localparam int unsigned ProdW = 32;
  localparam int unsigned AccW  = 36;

  localparam int unsigned W16 = 16;
  localparam int unsigned W8  = 8;
  localparam int unsigned W4  = 4;

  localparam int unsigned Iter16 = 16;
  localparam int unsigned Iter8  = 8;
  localparam int unsigned Iter4  = 4;

  // Each lane is {A,Q,Q-1}; lane k starts at k * stride within accum.
  localparam int unsigned Off16   = 0;
  localparam int unsigned Stride8 = 2 * W8 + 1;
  localparam int unsigned Stride4 = 2 * W4 + 1;

  function automatic logic [3:0] iter_last(mode_e m);
    unique case (m)
      Mode1x16: iter_last = 4'(Iter16 - 1);
      Mode2x8:  iter_last = 4'(Iter8 - 1);
      Mode4x4:  iter_last = 4'(Iter4 - 1);
      default:  iter_last = 4'd0;
    endcase
  endfunction

  function automatic logic [AccW-1:0] load_accum(mode_e m, logic [DataW-1:0] mp);
    logic [AccW-1:0] acc;
    acc = '0;
    unique case (m)
      Mode1x16: acc[Off16 + 1 +: W16] = mp;
      Mode2x8: begin
        for (int k = 0; k < 2; k++) acc[k * Stride8 + 1 +: W8] = mp[k * W8 +: W8];
      end
      Mode4x4: begin
        for (int k = 0; k < 4; k++) acc[k * Stride4 + 1 +: W4] = mp[k * W4 +: W4];
      end
      default: acc = '0;
    endcase
    return acc;
  endfunction

  function automatic logic [ProdW-1:0] pack_product(mode_e m, logic [AccW-1:0] acc);
    logic [ProdW-1:0] p;
    p = '0;
    unique case (m)
      Mode1x16: p = acc[Off16 + 1 +: 2 * W16];
      Mode2x8: begin
        for (int k = 0; k < 2; k++) p[k * 2 * W8 +: 2 * W8] = acc[k * Stride8 + 1 +: 2 * W8];
      end
      Mode4x4: begin
        for (int k = 0; k < 4; k++) p[k * 2 * W4 +: 2 * W4] = acc[k * Stride4 + 1 +: 2 * W4];
      end
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/booth_iter_ctrl_if.sv
// Request/response and encoder-facing signals of the Booth iteration controller.
interface booth_iter_ctrl_if;
  import booth_pkg::*;

  logic             start;
  logic [1:0]       mode;
  logic [DataW-1:0] multiplicand;
  logic [DataW-1:0] multiplier;
  logic [DataW-1:0] M_out;
  logic [3:0]       flags;
  logic [AccW-1:0]  accum;
  logic [DataW-1:0] M;
  logic [1:0]       mode_q;
  logic             busy;
  logic             done;
  logic             err;
  logic [ProdW-1:0] product;

  modport master (
    output start, mode, multiplicand, multiplier, M_out, flags,
    input  accum, M, mode_q, busy, done, err, product
  );

  modport slave (
    input  start, mode, multiplicand, multiplier, M_out, flags,
    output accum, M, mode_q, busy, done, err, product
  );

endinterface

// File: rtl/booth_lane_step.sv
// One Booth iteration for a single lane: add/subtract into A, then arithmetic shift {A,Q,Q-1}.
module booth_lane_step #(
  parameter int unsigned W = 8
) (
  input  logic [2*W:0] lane_i,
  input  logic [W-1:0] m_i,
  input  logic         sub_i,
  output logic [2*W:0] lane_o
);

  logic [W-1:0] a;
  logic [W-1:0] a_next;

  always_comb begin
    a      = lane_i[2*W:W+1];
    a_next = sub_i ? (a - m_i) : (a + m_i);
    // Old Q-1 drops out; sign of A' refills the top.
    lane_o = {a_next[W-1], a_next, lane_i[W:1]};
  end

endmodule

// File: rtl/booth_iter_ctrl.sv
// Iterative radix-2 Booth controller: one 16x16, two 8x8 or four 4x4 signed lanes.
module booth_iter_ctrl
  import booth_pkg::*;
(
  input logic               clk,
  input logic               rst,
  booth_iter_ctrl_if.slave  bus_io
);

  state_e           state_q;
  mode_e            mode_q;
  mode_e            mode_in;
  logic [AccW-1:0]  accum_q;
  logic [AccW-1:0]  step_acc;
  logic [DataW-1:0] m_q;
  logic [ProdW-1:0] product_q;
  logic [3:0]       cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  assign mode_in = mode_e'(bus_io.mode);

  logic [2*W16:0] s16;
  logic [2*W8:0]  s8 [2];
  logic [2*W4:0]  s4 [4];

  booth_lane_step #(.W(W16)) u_step16 (
    .lane_i (accum_q[Off16 +: 2 * W16 + 1]),
    .m_i    (bus_io.M_out[W16-1:0]),
    .sub_i  (bus_io.flags[0]),
    .lane_o (s16)
  );

  for (genvar k = 0; k < 2; k++) begin : g_lane8
    booth_lane_step #(.W(W8)) u_step (
      .lane_i (accum_q[k * Stride8 +: Stride8]),
      .m_i    (bus_io.M_out[k * W8 +: W8]),
      .sub_i  (bus_io.flags[2 * k]),
      .lane_o (s8[k])
    );
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane4
    booth_lane_step #(.W(W4)) u_step (
      .lane_i (accum_q[k * Stride4 +: Stride4]),
      .m_i    (bus_io.M_out[k * W4 +: W4]),
      .sub_i  (bus_io.flags[k]),
      .lane_o (s4[k])
    );
  end

  // Unused high accum bits stay zero because they are never written by a lane.
  always_comb begin
    step_acc = '0;
    unique case (mode_q)
      Mode1x16: step_acc[Off16 +: 2 * W16 + 1] = s16;
      Mode2x8: begin
        for (int k = 0; k < 2; k++) step_acc[k * Stride8 +: Stride8] = s8[k];
      end
      Mode4x4: begin
        for (int k = 0; k < 4; k++) step_acc[k * Stride4 +: Stride4] = s4[k];
      end
      default: step_acc = accum_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      mode_q    <= Mode1x16;
      accum_q   <= '0;
      m_q       <= '0;
      product_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            if (mode_in == ModeRsvd) begin
              err_q <= 1'b1;
            end else begin
              state_q <= StRun;
              busy_q  <= 1'b1;
              mode_q  <= mode_in;
              m_q     <= bus_io.multiplicand;
              accum_q <= load_accum(mode_in, bus_io.multiplier);
              cnt_q   <= '0;
            end
          end
        end
        StRun: begin
          accum_q <= step_acc;
          cnt_q   <= cnt_q + 4'd1;
          if (cnt_q == iter_last(mode_q)) begin
            state_q   <= StDone;
            done_q    <= 1'b1;
            product_q <= pack_product(mode_q, step_acc);
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.accum   = accum_q;
  assign bus_io.M       = m_q;
  assign bus_io.mode_q  = mode_q;
  assign bus_io.busy    = busy_q;
  assign bus_io.done    = done_q;
  assign bus_io.err     = err_q;
  assign bus_io.product = product_q;

endmodule

// File: tb/tb_booth_iter_ctrl.sv
// Bench wrapping the controller with a radix-2 Booth encoder model; scoreboard checks products.
module tb_booth_iter_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  booth_iter_ctrl_if bus ();

  booth_iter_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  // Booth encoder: pair {Q0,Q-1} = 01 adds M, 10 subtracts M, otherwise no-op.
  function automatic logic booth_use(input logic [1:0] pair);
    return pair[1] ^ pair[0];
  endfunction

  function automatic logic booth_sub(input logic [1:0] pair);
    return pair[1] & ~pair[0];
  endfunction

  always_comb begin
    bus.M_out = '0;
    bus.flags = '0;
    case (bus.mode_q)
      2'b00: begin
        bus.M_out    = booth_use(bus.accum[1:0]) ? bus.M : 16'h0000;
        bus.flags[0] = booth_sub(bus.accum[1:0]);
      end
      2'b01: begin
        for (int k = 0; k < 2; k++) begin
          bus.M_out[k*8 +: 8] = booth_use(bus.accum[k*17 +: 2]) ? bus.M[k*8 +: 8] : 8'h00;
          bus.flags[2*k]      = booth_sub(bus.accum[k*17 +: 2]);
        end
      end
      2'b10: begin
        for (int k = 0; k < 4; k++) begin
          bus.M_out[k*4 +: 4] = booth_use(bus.accum[k*9 +: 2]) ? bus.M[k*4 +: 4] : 4'h0;
          bus.flags[k]        = booth_sub(bus.accum[k*9 +: 2]);
        end
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [31:0] prod;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: product 0x%0h at cycle %0d, expected no done", bus.product,
                 cyc);
      end else begin
        e = exp_q.pop_front();
        check("product", bus.product, e.prod);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input logic [1:0] md, input logic [15:0] mc, input logic [15:0] mp,
                       input logic [31:0] exp, input int n);
    exp_t e;
    @(negedge clk);
    bus.start        = 1'b1;
    bus.mode         = md;
    bus.multiplicand = mc;
    bus.multiplier   = mp;
    e.prod = exp;
    e.cyc  = cyc + 1 + n;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || bus.busy) && i < max_cyc) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() != 0 || bus.busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results pending, busy=%0b after %0d cycles, expected 0",
               exp_q.size(), bus.busy, max_cyc);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   d0;
    exp_t e;
    bus.start        = 1'b0;
    bus.mode         = 2'b00;
    bus.multiplicand = 16'h0000;
    bus.multiplier   = 16'h0000;

    #1 rst = 1'b1;
    #20;
    check("rst_accum", bus.accum, 36'h0);
    check("rst_M", bus.M, 16'h0);
    check("rst_mode_q", bus.mode_q, 2'b00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_product", bus.product, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic products in each mode, including lane boundaries.
    issue(2'b00, 16'h0007, 16'hFFFD, 32'hFFFFFFEB, 16);
    @(negedge clk);
    check("busy_in_run", bus.busy, 1'b1);
    drain(40);
    repeat (3) @(negedge clk);
    check("product_hold", bus.product, 32'hFFFFFFEB);

    issue(2'b01, 16'h05FA, 16'h0304, 32'h000FFFE8, 8);
    drain(40);
    issue(2'b10, 16'h7F3A, 16'h2222, 32'h0EFE06F4, 4);
    drain(40);
    issue(2'b00, 16'hFED4, 16'h007B, 32'hFFFF6FDC, 16);
    drain(40);
    issue(2'b01, 16'h7FFF, 16'h8180, 32'hC0FF0080, 8);
    drain(40);

    // start pulsed mid-RUN is ignored.
    d0 = done_cnt;
    issue(2'b10, 16'h1234, 16'h1111, 32'h01020304, 4);
    bus.start        = 1'b1;
    bus.mode         = 2'b00;
    bus.multiplicand = 16'h0100;
    bus.multiplier   = 16'h0003;
    @(negedge clk);
    bus.start = 1'b0;
    drain(40);
    check("single_done", done_cnt - d0, 1);

    // Reserved mode: err pulse only.
    @(negedge clk);
    bus.start        = 1'b1;
    bus.mode         = 2'b11;
    bus.multiplicand = 16'hAAAA;
    bus.multiplier   = 16'h5555;
    @(negedge clk);
    bus.start = 1'b0;
    check("err_pulse", bus.err, 1'b1);
    check("err_busy", bus.busy, 1'b0);
    check("err_mode_q", bus.mode_q, 2'b10);
    check("err_M", bus.M, 16'h1234);
    check("err_product", bus.product, 32'h01020304);
    @(negedge clk);
    check("err_clear", bus.err, 1'b0);
    check("err_busy_after", bus.busy, 1'b0);

    // Reset at RUN cycle 5 aborts without done.
    d0 = done_cnt;
    issue(2'b00, 16'h0007, 16'hFFFD, 32'hFFFFFFEB, 16);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_accum", bus.accum, 36'h0);
    check("abort_product", bus.product, 32'h0);
    check("abort_done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_product_after", bus.product, 32'h0);
    issue(2'b10, 16'h7F3A, 16'h2222, 32'h0EFE06F4, 4);
    drain(40);

    // Back-to-back with start held high: accepted every N+2 cycles.
    d0 = done_cnt;
    @(negedge clk);
    bus.start        = 1'b1;
    bus.mode         = 2'b01;
    bus.multiplicand = 16'h05FA;
    bus.multiplier   = 16'h0304;
    e.prod = 32'h000FFFE8;
    e.cyc  = cyc + 1 + 8;
    exp_q.push_back(e);
    e.prod = 32'hC0FF0080;
    e.cyc  = cyc + 1 + 10 + 8;
    exp_q.push_back(e);
    @(negedge clk);
    bus.multiplicand = 16'h7FFF;
    bus.multiplier   = 16'h8180;
    repeat (9) @(negedge clk);
    check("b2b_hold_first", bus.product, 32'h000FFFE8);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b_hold_mid", bus.product, 32'h000FFFE8);
    check("b2b_busy", bus.busy, 1'b1);
    drain(40);
    check("b2b_done_count", done_cnt - d0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
